// File: rtl/led_pwm_ctrl_pkg.sv
// Shared definitions for the multi-channel LED PWM driver:
// channel mode encodings and their width.
package led_pwm_ctrl_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_OFF     = 3'd0;
  localparam logic [MODE_W-1:0] MODE_ON      = 3'd1;
  localparam logic [MODE_W-1:0] MODE_PWM     = 3'd2;
  localparam logic [MODE_W-1:0] MODE_BLINK   = 3'd3;
  localparam logic [MODE_W-1:0] MODE_BREATHE = 3'd4;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: holds mode/level config plus blink and breathe phase,
// and registers the LED drive from the shared PWM counter.
module led_pwm_channel
  import led_pwm_ctrl_pkg::*;
#(
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic [MODE_W-1:0]    mode,
  input  logic [PWM_WIDTH-1:0] level,
  input  logic [PWM_WIDTH-1:0] pwm_cnt,
  input  logic                 wrap,
  output logic                 led
);

  localparam logic [PWM_WIDTH-1:0] ONE_W = PWM_WIDTH'(1);
  localparam logic [PWM_WIDTH-1:0] MAX_W = '1;

  logic [MODE_W-1:0]    mode_q, mode_d;
  logic [PWM_WIDTH-1:0] level_q, level_d;
  logic [PWM_WIDTH-1:0] blink_cnt_q, blink_cnt_d;
  logic                 blink_q, blink_d;
  logic [PWM_WIDTH-1:0] duty_q, duty_d;
  logic                 dir_q, dir_d;
  logic                 led_q, led_d;

  always_comb begin
    mode_d      = mode_q;
    level_d     = level_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    duty_d      = duty_q;
    dir_d       = dir_q;
    // A write wins over a coincident wrap so the restarted phase starts clean.
    if (wr) begin
      mode_d      = mode;
      level_d     = level;
      blink_cnt_d = '0;
      blink_d     = 1'b0;
      duty_d      = '0;
      dir_d       = 1'b0;
    end else if (wrap) begin
      case (mode_q)
        MODE_BLINK: begin
          if (blink_cnt_q == level_q) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
          end else begin
            blink_cnt_d = blink_cnt_q + ONE_W;
          end
        end
        MODE_BREATHE: begin
          if (!dir_q) begin
            duty_d = duty_q + ONE_W;
            if (duty_q == MAX_W - ONE_W) dir_d = 1'b1;
          end else begin
            duty_d = duty_q - ONE_W;
            if (duty_q == ONE_W) dir_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    led_d = 1'b0;
    case (mode_q)
      MODE_ON:      led_d = 1'b1;
      MODE_PWM:     led_d = (pwm_cnt < level_q);
      MODE_BLINK:   led_d = blink_q;
      MODE_BREATHE: led_d = (pwm_cnt < duty_q);
      default:      led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= MODE_OFF;
      level_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      duty_q      <= '0;
      dir_q       <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      level_q     <= level_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      duty_q      <= duty_d;
      dir_q       <= dir_d;
      led_q       <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED driver top: shared prescaler and PWM counter, wrap
// generation and config write decode feeding one led_pwm_channel per LED.
module led_pwm_ctrl
  import led_pwm_ctrl_pkg::*;
#(
  parameter int N_LED       = 4,
  parameter int PWM_WIDTH   = 8,
  parameter int PRESC_WIDTH = 16,
  parameter int CH_WIDTH    = (N_LED > 1) ? $clog2(N_LED) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PRESC_WIDTH-1:0] i_presc,
  input  logic                   i_wr_en,
  input  logic [CH_WIDTH-1:0]    i_wr_ch,
  input  logic [MODE_W-1:0]      i_wr_mode,
  input  logic [PWM_WIDTH-1:0]   i_wr_level,
  output logic [N_LED-1:0]       o_led,
  output logic                   o_tick
);

  localparam logic [PWM_WIDTH-1:0] PWM_MAX = '1;

  logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
  logic [PWM_WIDTH-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic                   o_tick_q, o_tick_d;
  logic                   tick;
  logic                   wrap;
  logic                   wr_in_range;

  // >= (not ==) so lowering i_presc below the running count wraps at once.
  always_comb begin
    tick        = (presc_cnt_q >= i_presc);
    presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_WIDTH'(1);
    pwm_cnt_d   = tick ? pwm_cnt_q + PWM_WIDTH'(1) : pwm_cnt_q;
    wrap        = tick && (pwm_cnt_q == PWM_MAX);
    o_tick_d    = tick;
    wr_in_range = i_wr_en && ({1'b0, i_wr_ch} < (CH_WIDTH + 1)'(N_LED));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      o_tick_q    <= 1'b0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      o_tick_q    <= o_tick_d;
    end
  end

  assign o_tick = o_tick_q;

  for (genvar g = 0; g < N_LED; g++) begin : g_ch
    logic ch_wr;
    assign ch_wr = wr_in_range && (i_wr_ch == CH_WIDTH'(g));

    led_pwm_channel #(
      .PWM_WIDTH (PWM_WIDTH)
    ) u_channel (
      .clk     (clk),
      .rst     (rst),
      .wr      (ch_wr),
      .mode    (i_wr_mode),
      .level   (i_wr_level),
      .pwm_cnt (pwm_cnt_q),
      .wrap    (wrap),
      .led     (o_led[g])
    );
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Bench for led_pwm_ctrl: directed scenarios plus random config writes,
// checked cycle by cycle against a period-counting reference model.
module tb_led_pwm_ctrl;

  localparam int NL   = 4;
  localparam int W    = 4;
  localparam int PW   = 16;
  localparam int MAXV = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] i_presc = '0;
  logic          i_wr_en = 1'b0;
  logic [1:0]    i_wr_ch = '0;
  logic [2:0]    i_wr_mode = '0;
  logic [W-1:0]  i_wr_level = '0;
  logic [NL-1:0] o_led;
  logic          o_tick;

  // Second instance with a channel count that leaves an unused index.
  logic          wr3_en = 1'b0;
  logic [1:0]    wr3_ch = '0;
  logic [2:0]    wr3_mode = '0;
  logic [2:0]    o_led3;
  logic          o_tick3;

  int n_pass  = 0;
  int n_total = 0;

  logic [NL:0] exp_q[$];

  led_pwm_ctrl #(.N_LED(NL), .PWM_WIDTH(W), .PRESC_WIDTH(PW)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .i_presc    (i_presc),
    .i_wr_en    (i_wr_en),
    .i_wr_ch    (i_wr_ch),
    .i_wr_mode  (i_wr_mode),
    .i_wr_level (i_wr_level),
    .o_led      (o_led),
    .o_tick     (o_tick)
  );

  led_pwm_ctrl #(.N_LED(3), .PWM_WIDTH(W), .PRESC_WIDTH(PW)) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .i_presc    ('0),
    .i_wr_en    (wr3_en),
    .i_wr_ch    (wr3_ch),
    .i_wr_mode  (wr3_mode),
    .i_wr_level ('0),
    .o_led      (o_led3),
    .o_tick     (o_tick3)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Channel phase is tracked as "PWM periods completed since the last write";
  // blink level and breathe duty are derived from it arithmetically.
  int m_presc, m_pwm;
  int m_mode[NL], m_level[NL], m_n[NL];

  function automatic int tri_duty(input int n);
    int p;
    p = n % (2 * MAXV);
    return (p <= MAXV) ? p : (2 * MAXV - p);
  endfunction

  function automatic logic model_led(input int c);
    case (m_mode[c])
      1:       return 1'b1;
      2:       return m_pwm < m_level[c];
      3:       return ((m_n[c] / (m_level[c] + 1)) % 2) == 1;
      4:       return m_pwm < tri_duty(m_n[c]);
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin : model_blk
    logic [NL:0] e;
    bit tk;
    e = '0;
    if (rst) begin
      m_presc = 0;
      m_pwm   = 0;
      for (int c = 0; c < NL; c++) begin
        m_mode[c] = 0; m_level[c] = 0; m_n[c] = 0;
      end
    end else begin
      tk = (m_presc >= int'(i_presc));
      e[NL] = tk;
      for (int c = 0; c < NL; c++) e[c] = model_led(c);
      for (int c = 0; c < NL; c++) begin
        if (i_wr_en && int'(i_wr_ch) == c) begin
          m_mode[c] = int'(i_wr_mode); m_level[c] = int'(i_wr_level); m_n[c] = 0;
        end else if (tk && m_pwm == MAXV) begin
          m_n[c]++;
        end
      end
      if (tk) m_pwm = (m_pwm + 1) % (MAXV + 1);
      m_presc = tk ? 0 : m_presc + 1;
    end
    exp_q.push_back(e);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon_blk
    logic [NL:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rst) check("reset_outputs", {27'd0, o_tick, o_led}, 32'd0);
      else     check("led_tick", {27'd0, o_tick, o_led}, {27'd0, e});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic write_ch(input int ch, input int mode, input int level);
    i_wr_en    = 1'b1;
    i_wr_ch    = 2'(ch);
    i_wr_mode  = 3'(mode);
    i_wr_level = W'(level);
    step();
    i_wr_en    = 1'b0;
  endtask

  task automatic count_high(input int ch, input int ncyc, output int cnt);
    cnt = 0;
    @(negedge clk);
    repeat (ncyc) begin
      @(negedge clk);
      cnt += int'(o_led[ch]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    bit seen;

    // Writes while reset is held must be lost.
    step(2);
    write_ch(0, 1, 0);
    write_ch(2, 3, 0);
    step(2);
    rst = 1'b0;
    step(40);

    // ON / OFF latency, others stay off.
    write_ch(0, 1, 0);
    step(5);
    write_ch(0, 0, 0);
    step(5);

    // PWM duty counts over one 16-cycle period.
    write_ch(1, 2, 4);
    count_high(1, 16, cnt);
    check("pwm_level4", cnt, 4);
    write_ch(1, 2, 0);
    count_high(1, 16, cnt);
    check("pwm_level0", cnt, 0);
    write_ch(1, 2, 15);
    count_high(1, 16, cnt);
    check("pwm_level15", cnt, 15);

    // Blink with 32-cycle half-period, breathe full ramp plus restart.
    write_ch(2, 3, 1);
    write_ch(3, 4, 0);
    step(520);
    write_ch(3, 4, 0);
    step(120);

    // Unused channel index on the 3-channel instance changes nothing.
    wr3_en = 1'b1; wr3_ch = 2'd3; wr3_mode = 3'd1;
    step();
    wr3_en = 1'b0;
    step(3);
    check("oor_write_ignored", {29'd0, o_led3}, 32'd0);
    wr3_en = 1'b1; wr3_ch = 2'd2; wr3_mode = 3'd1;
    step();
    wr3_en = 1'b0;
    step(2);
    check("inrange_write_n3", {29'd0, o_led3}, 32'h4);

    // Prescaler: one tick per three cycles.
    i_presc = 16'd2;
    step(6);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      cnt += int'(o_tick);
    end
    check("presc2_tick_count", cnt, 10);

    // Lower the terminal value while the count sits at 5.
    i_presc = 16'd9;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (o_tick) seen = 1'b1;
    end
    check("presc9_tick_seen", {31'd0, seen}, 32'd1);
    step(5);
    i_presc = 16'd2;
    step();
    @(negedge clk);
    check("presc_drop_tick", {31'd0, o_tick}, 32'd1);
    i_presc = 16'd0;

    // Reset in the middle of blinking.
    write_ch(2, 3, 0);
    step(40);
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(20);

    // Random configuration traffic.
    repeat (60) begin
      i_presc = PW'($urandom_range(0, 3));
      write_ch($urandom_range(0, NL - 1), $urandom_range(0, 7), $urandom_range(0, MAXV));
      if ($urandom_range(0, 3) == 0)
        write_ch($urandom_range(0, NL - 1), $urandom_range(3, 4), $urandom_range(0, 2));
      step($urandom_range(1, 40));
    end

    step(2);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
